// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multi-cycle MIPS datapath: Moore decode of the
// datapath controls per state, with branch qualification from the ALU zero flag.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rstN,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [3:0] aluOperation,
    output logic       illegalInstr,
    output logic [3:0] stateOut
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12,
        S_IDLE   = 4'd13
    } state_t;

    state_t state_q, state_d;

    // opcode is only looked at in DECODE, so the lw/sw and beq/bne choices
    // are captured there for use in the later states.
    logic is_store_q, is_store_d;
    logic is_bne_q, is_bne_d;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: funct_legal = 1'b1;
            default:                                       funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_aluop(input logic [5:0] f);
        case (f)
            FN_ADD:  funct_aluop = ALU_ADD;
            FN_SUB:  funct_aluop = ALU_SUB;
            FN_AND:  funct_aluop = ALU_AND;
            FN_OR:   funct_aluop = ALU_OR;
            FN_NOR:  funct_aluop = ALU_NOR;
            FN_SLT:  funct_aluop = ALU_SLT;
            default: funct_aluop = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            is_bne_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            is_bne_q   <= is_bne_d;
        end
    end

    // memReady is a completion strobe from memory: a FETCH/MEMRD/MEMWR access
    // finishes in the cycle it is high and stalls otherwise; no other state
    // looks at it and there is no ready/valid back-pressure toward memory.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        is_bne_d   = is_bne_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW: begin
                        state_d    = S_MEMADR;
                        is_store_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d    = S_MEMADR;
                        is_store_d = 1'b1;
                    end
                    OP_RTYPE: state_d = funct_legal(funct) ? S_RTEXEC : S_TRAP;
                    OP_BEQ: begin
                        state_d  = S_BRANCH;
                        is_bne_d = 1'b0;
                    end
                    OP_BNE: begin
                        state_d  = S_BRANCH;
                        is_bne_d = 1'b1;
                    end
                    OP_ADDI:  state_d = S_IEXEC;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (memReady) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (memReady) state_d = S_FETCH;
            S_RTEXEC: state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pcWrite      = 1'b0;
        iorD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        regDst       = 1'b0;
        memToReg     = 1'b0;
        regWrite     = 1'b0;
        aluSrcA      = 1'b0;
        aluSrcB      = 2'b00;
        pcSource     = 2'b00;
        aluOperation = ALU_ADD;
        illegalInstr = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: aluSrcB = 2'b11;
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_RTEXEC: begin
                aluSrcA      = 1'b1;
                aluOperation = funct_aluop(funct);
            end
            S_RTWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA      = 1'b1;
                aluOperation = ALU_SUB;
                pcSource     = 2'b01;
                pcWrite      = is_bne_q ? ~zero : zero;
            end
            S_IEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_IWB:  regWrite = 1'b1;
            S_JUMP: begin
                pcSource = 2'b10;
                pcWrite  = 1'b1;
            end
            S_TRAP: illegalInstr = 1'b1;
            default: ;
        endcase
    end

    assign stateOut = state_q;

endmodule
